rr_mux_n: RTL and testbench

RR_MUX_N -- requirements
Module: rr_mux_n

---
 rtl/rr_mux_pkg.sv | 14 +
 rtl/rr_arb.sv | 30 +++
 rtl/rr_mux_n.sv | 94 +++++++++
 tb/tb_rr_mux_n.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared encodings for the round-robin/direct-select mux: output-register state and mode values.
// No logic or latency of its own.
// No flow control here; the users of these encodings handle backpressure.
package rr_mux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arb.sv
// Round-robin search: grants the first requester at or above ptr, wrapping past N-1.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the grant is used.
module rr_arb #(
    parameter  int N  = 6,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          grant_vld
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!grant_vld && req[idx]) begin
                grant     = PW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N:1 mux, direct select or round-robin, into one output register; RR_MUX_GRANT_CNT_EN adds grant_cnt.
// One cycle from input transfer to out_valid.
// in_ready only while the register is empty or draining this cycle (pass-through, no bubble).
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 6,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef RR_MUX_GRANT_CNT_EN
    ,
    output logic [15:0]               grant_cnt
`endif
);

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] dsel;
    logic [SELW-1:0] arb_grant;
    logic [SELW-1:0] gnt;
    logic            arb_vld;
    logic            reg_free;
    logic            take;

    // Out-of-range select clamps to the top channel.
    assign dsel = (int'(sel) >= CHANNELS) ? SELW'(CHANNELS - 1) : sel;

    rr_arb #(.N(CHANNELS)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_vld (arb_vld)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        gnt       = (mode == MODE_RR) ? arb_grant : dsel;
        reg_free  = (state == ST_EMPTY) || out_ready;
        if (!rst && reg_free) begin
            if (mode == MODE_RR) begin
                if (arb_vld) in_ready[arb_grant] = 1'b1;
            end else begin
                in_ready[dsel] = 1'b1;
            end
        end
        take = |(in_ready & in_valid);
        if (take) begin
            state_nxt = ST_FULL;
        end else if (state == ST_FULL && out_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_chan <= '0;
            ptr      <= '0;
        end else if (take) begin
            out_data <= in_data[gnt*WIDTH +: WIDTH];
            out_chan <= gnt;
            if (mode == MODE_RR)
                ptr <= (int'(gnt) == CHANNELS - 1) ? '0 : gnt + SELW'(1);
        end
    end

    assign out_valid = (state == ST_FULL);

`ifdef RR_MUX_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)       grant_cnt <= '0;
        else if (take) grant_cnt <= grant_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// Randomized and directed bench for rr_mux_n against a cycle-level behavioural model.
module tb_rr_mux_n;

    localparam int W  = 16;
    localparam int C  = 6;
    localparam int SW = $clog2(C);

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [C*W-1:0]  in_data;
    logic [C-1:0]    in_valid;
    logic [C-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;
`ifdef RR_MUX_GRANT_CNT_EN
    logic [15:0]     grant_cnt;
`endif

    always #5 clk = ~clk;

    rr_mux_n #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_MUX_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model of the output register and arbitration pointer.
    bit          m_full;
    logic [W-1:0] m_data;
    int          m_chan;
    int          m_ptr;
    int          m_cnt;

    task automatic model_reset();
        m_full = 0; m_data = '0; m_chan = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic step();
        logic [C-1:0] exp_rdy;
        bit           free;
        bit           found;
        bit           xfer;
        int           g;
        #1;
        exp_rdy = '0; found = 0; xfer = 0; g = 0;
        free = !m_full || out_ready;
        if (!rst && free) begin
            if (mode == 1'b0) begin
                g = (int'(sel) >= C) ? C - 1 : int'(sel);
                exp_rdy[g] = 1'b1;
                xfer = in_valid[g];
            end else begin
                for (int j = 0; j < C; j++) begin
                    int c;
                    c = (m_ptr + j) % C;
                    if (!found && in_valid[c]) begin
                        found = 1; g = c;
                    end
                end
                if (found) exp_rdy[g] = 1'b1;
                xfer = found;
            end
        end
        chk("in_ready",  in_ready,  exp_rdy);
        chk("out_valid", out_valid, m_full);
        chk("out_data",  out_data,  m_data);
        chk("out_chan",  out_chan,  m_chan);
`ifdef RR_MUX_GRANT_CNT_EN
        chk("grant_cnt", grant_cnt, m_cnt);
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (xfer) begin
            m_full = 1;
            m_data = in_data[g*W +: W];
            m_chan = g;
            m_cnt  = (m_cnt + 1) % 65536;
            if (mode) m_ptr = (g + 1) % C;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int k = 0; k < C; k++) in_data[k*W +: W] = W'($urandom);
    endtask

    logic [W-1:0] held;

    initial begin
        model_reset();
        rst = 1; mode = 0; sel = '0; in_valid = '1; in_data = '0; out_ready = 0;
        @(negedge clk);
        step();
        step();
        chk("rst_valid", out_valid, 0);
        rst = 0;

        // Direct select, channel 2.
        mode = 0; sel = 3'd2; in_valid = 6'b000100; rand_data();
        in_data[2*W +: W] = 16'h1234; out_ready = 1;
        step();
        chk("sel2_data", out_data, 16'h1234);
        chk("sel2_chan", out_chan, 2);
        chk("sel2_valid", out_valid, 1);

        // Select above range clamps to channel 5.
        sel = 3'd7; in_valid = '1; rand_data(); in_data[5*W +: W] = 16'hABCD;
        #1 chk("sel7_rdy", in_ready, 6'b100000);
        step();
        chk("sel7_chan", out_chan, 5);
        chk("sel7_data", out_data, 16'hABCD);

        // Round-robin rotation with all requesters active.
        mode = 1; in_valid = '1; out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            rand_data();
            step();
            chk("rr_seq", out_chan, i % C);
        end

        // Backpressure: held output stays put, nothing accepted.
        out_ready = 0; held = out_data;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1 chk("bp_rdy", in_ready, 0);
            step();
            chk("bp_data", out_data, held);
            chk("bp_chan", out_chan, 0);
        end
        out_ready = 1;
        #1 chk("bp_release", out_data, held);
        step();
        chk("bp_next_chan", out_chan, 1);

        // Reach ptr=3 while full, then reset.
        rand_data(); step();
        chk("pre_rst_chan", out_chan, 2);
        out_ready = 0; rst = 1;
        step();
        chk("rst_full_valid", out_valid, 0);
        chk("rst_full_chan", out_chan, 0);
        rst = 0; out_ready = 1; in_valid = '1;
        #1 chk("rst_first_rdy", in_ready, 6'b000001);
        step();
        chk("rst_first_chan", out_chan, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            mode      = 1'($urandom);
            sel       = SW'($urandom);
            in_valid  = C'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            step();
        end

`ifdef RR_MUX_GRANT_CNT_EN
        rst = 1; step(); rst = 0;
        mode = 1; in_valid = '1; out_ready = 1;
        for (int i = 0; i < 65536; i++) step();
        chk("cnt_wrap", grant_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
